// File: rtl/xor_path_sched.sv
// rtl/xor_path_sched.sv - two-channel round-robin scheduler sharing one XOR dut between FIFO pairs
// Optional sticky credit-overflow flag: define XOR_PATH_SCHED_ERR_EN
module xor_path_sched #(
   parameter int DUT_LAT   = 1,
   parameter int OUT_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] in_empty,
   input  logic [1:0] in_data0,
   input  logic [1:0] in_data1,
   output logic [1:0] in_rd_en,
   output logic       dut_a,
   output logic       dut_b,
   input  logic       dut_out,
   output logic [1:0] out_wr_en,
   output logic       out_din,
   input  logic [1:0] out_rd,
   output logic       busy,
   output logic       err
);

   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam logic [CW-1:0] CMAX = CW'(OUT_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state;
   logic              lp;
   logic [CW-1:0]     credit [2];
   logic [DUT_LAT:0]  tag_v;
   logic [DUT_LAT:0]  tag_id;

   logic [1:0]        elig;
   logic [1:0]        grant;
   logic [1:0]        full;
   logic [1:0]        inc;
   logic              issue;
   logic              pending;

   always_comb begin
      issue = (state == RUN) && en;
      for (int ch = 0; ch < 2; ch++) begin
         full[ch] = (credit[ch] == CMAX);
         elig[ch] = !in_empty[ch] && (credit[ch] != '0);
         inc[ch]  = out_rd[ch] && !full[ch];
      end
      grant = 2'b00;
      if (issue) begin
         if (elig[0] && (!elig[1] || lp))
            grant = 2'b01;
         else if (elig[1])
            grant = 2'b10;
      end
   end

   // Ops still in the line after this edge; the last stage retires this cycle.
   assign pending   = |tag_v[DUT_LAT-1:0];
   assign in_rd_en  = grant;
   assign out_wr_en = {tag_v[DUT_LAT] & tag_id[DUT_LAT], tag_v[DUT_LAT] & ~tag_id[DUT_LAT]};
   assign out_din   = tag_v[DUT_LAT] & dut_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         lp     <= 1'b1;
         dut_a  <= 1'b0;
         dut_b  <= 1'b0;
         tag_v  <= '0;
         tag_id <= '0;
         for (int ch = 0; ch < 2; ch++)
            credit[ch] <= CMAX;
      end else begin
         tag_v  <= {tag_v[DUT_LAT-1:0], |grant};
         tag_id <= {tag_id[DUT_LAT-1:0], grant[1]};
         if (|grant) begin
            {dut_a, dut_b} <= grant[1] ? in_data1 : in_data0;
            lp             <= grant[1];
         end
         for (int ch = 0; ch < 2; ch++) begin
            if (inc[ch] && !grant[ch])
               credit[ch] <= credit[ch] + CW'(1);
            else if (grant[ch] && !inc[ch])
               credit[ch] <= credit[ch] - CW'(1);
         end
         case (state)
            IDLE: begin
               if (en) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (!en) begin
                  state <= pending ? DRAIN : IDLE;
                  busy  <= pending;
               end
            end
            DRAIN: begin
               if (en) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end else if (!pending) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef XOR_PATH_SCHED_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err <= 1'b0;
      else if (|(out_rd & full))
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_xor_path_sched.sv
// tb/tb_xor_path_sched.sv - directed self-checking bench for xor_path_sched
// Honours XOR_PATH_SCHED_ERR_EN for the expected err value
module tb_xor_path_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [1:0] in_empty;
   logic [1:0] in_data0;
   logic [1:0] in_data1;
   logic [1:0] in_rd_en;
   logic       dut_a;
   logic       dut_b;
   logic       dut_out;
   logic [1:0] out_wr_en;
   logic       out_din;
   logic [1:0] out_rd = 2'b00;
   logic       busy;
   logic       err;

`ifdef XOR_PATH_SCHED_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   int n_assert = 0;
   int n_fail = 0;

   logic [1:0] f0 [128];
   logic [1:0] f1 [128];
   int n0 = 0, n1 = 0;
   int pop0 = 0, pop1 = 0;
   int wcnt0 = 0, wcnt1 = 0, bad = 0;
   logic d1 = 1'b0;
   int base0, base1, wbase;
   logic [5:0] exp_din;

   always #5 clk = ~clk;

   xor_path_sched #(.DUT_LAT(1), .OUT_DEPTH(8)) u_dut (
      .clk(clk), .rst(rst), .en(en),
      .in_empty(in_empty), .in_data0(in_data0), .in_data1(in_data1),
      .in_rd_en(in_rd_en), .dut_a(dut_a), .dut_b(dut_b), .dut_out(dut_out),
      .out_wr_en(out_wr_en), .out_din(out_din), .out_rd(out_rd),
      .busy(busy), .err(err)
   );

   always_comb begin
      in_empty[0] = (pop0 >= n0);
      in_empty[1] = (pop1 >= n1);
      in_data0    = f0[pop0 & 127];
      in_data1    = f1[pop1 & 127];
   end

   assign dut_out = d1;

   always @(posedge clk) begin
      if (in_rd_en[0]) pop0 <= pop0 + 1;
      if (in_rd_en[1]) pop1 <= pop1 + 1;
      if (out_wr_en[0]) wcnt0 <= wcnt0 + 1;
      if (out_wr_en[1]) wcnt1 <= wcnt1 + 1;
      if (out_wr_en == 2'b11 || in_rd_en == 2'b11) bad <= bad + 1;
      d1 <= dut_a ^ dut_b;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push0(input logic [1:0] w);
      f0[n0 & 127] = w;
      n0++;
   endtask

   task automatic push1(input logic [1:0] w);
      f1[n1 & 127] = w;
      n1++;
   endtask

   task automatic reset_pulse();
      en  = 1'b0;
      rst = 1'b0;
      tick();
      n0  = pop0;
      n1  = pop1;
      rst = 1'b1;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         f0[i] = 2'b00;
         f1[i] = 2'b00;
      end

      // reset values
      repeat (3) tick();
      chk("rst_in_rd_en", 32'(in_rd_en), 0);
      chk("rst_dut_ab", 32'({dut_a, dut_b}), 0);
      chk("rst_out_wr_en", 32'(out_wr_en), 0);
      chk("rst_out_din", 32'(out_din), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      rst = 1'b1;
      tick();

      // single channel: 01,11,10 -> results 1,0,1
      push0(2'b01); push0(2'b11); push0(2'b10);
      en = 1'b1;
      #1;
      chk("sc_idle_rd", 32'(in_rd_en), 0);
      chk("sc_idle_busy", 32'(busy), 0);
      tick();
      chk("sc_rd1", 32'(in_rd_en), 1);
      chk("sc_busy", 32'(busy), 1);
      tick();
      chk("sc_rd2", 32'(in_rd_en), 1);
      chk("sc_ab0", 32'({dut_a, dut_b}), 32'(2'b01));
      tick();
      chk("sc_rd3", 32'(in_rd_en), 1);
      chk("sc_wr1", 32'(out_wr_en), 1);
      chk("sc_din1", 32'(out_din), 1);
      tick();
      en = 1'b0;
      #1;
      chk("sc_rd_off", 32'(in_rd_en), 0);
      chk("sc_wr2", 32'(out_wr_en), 1);
      chk("sc_din2", 32'(out_din), 0);
      tick();
      chk("sc_wr3", 32'(out_wr_en), 1);
      chk("sc_din3", 32'(out_din), 1);
      chk("sc_busy_drain", 32'(busy), 1);
      tick();
      chk("sc_wr_done", 32'(out_wr_en), 0);
      chk("sc_busy_low", 32'(busy), 0);
      chk("sc_ab_hold", 32'({dut_a, dut_b}), 32'(2'b10));

      // contention: grants alternate 0,1,0,1,0,1
      reset_pulse();
      push0(2'b01); push0(2'b10); push0(2'b00);
      push1(2'b11); push1(2'b01); push1(2'b11);
      exp_din = 6'b001101;
      en = 1'b1;
      #1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i <= 6)
            chk($sformatf("ct_rd%0d", i), 32'(in_rd_en), (i % 2 == 1) ? 1 : 2);
         else
            chk($sformatf("ct_rd%0d", i), 32'(in_rd_en), 0);
         if (i >= 3) begin
            chk($sformatf("ct_wr%0d", i), 32'(out_wr_en), (i % 2 == 1) ? 1 : 2);
            chk($sformatf("ct_din%0d", i), 32'(out_din), 32'(exp_din[i-3]));
         end
      end
      tick();
      push1(2'b10);
      #1;
      chk("ct_sole_ch1", 32'(in_rd_en), 2);
      chk("ct_wr_idle", 32'(out_wr_en), 0);
      tick();

      // backpressure: 8 credits, 10 words
      reset_pulse();
      for (int i = 0; i < 10; i++) push0(2'b01);
      base0 = pop0;
      wbase = wcnt0;
      en = 1'b1;
      #1;
      repeat (14) tick();
      chk("bp_pops", 32'(pop0 - base0), 8);
      chk("bp_writes", 32'(wcnt0 - wbase), 8);
      chk("bp_stall", 32'(in_rd_en), 0);
      out_rd = 2'b01;
      #1;
      chk("bp_same_cycle", 32'(in_rd_en), 0);
      tick();
      out_rd = 2'b00;
      #1;
      chk("bp_credit_pop", 32'(in_rd_en), 1);
      tick();
      chk("bp_stall_again", 32'(in_rd_en), 0);

      // drain: en falls one cycle after a pop
      reset_pulse();
      for (int i = 0; i < 6; i++) push0(2'b01);
      en = 1'b1;
      #1;
      tick();
      tick();
      tick();
      en = 1'b0;
      #1;
      chk("dr_no_pop", 32'(in_rd_en), 0);
      chk("dr_wr1", 32'(out_wr_en), 1);
      chk("dr_busy1", 32'(busy), 1);
      tick();
      chk("dr_no_pop2", 32'(in_rd_en), 0);
      chk("dr_wr2", 32'(out_wr_en), 1);
      chk("dr_busy2", 32'(busy), 1);
      tick();
      chk("dr_wr_done", 32'(out_wr_en), 0);
      chk("dr_busy_low", 32'(busy), 0);

      // reset mid-flight
      reset_pulse();
      push0(2'b11); push0(2'b11);
      en = 1'b1;
      #1;
      tick();
      chk("rf_pop", 32'(in_rd_en), 1);
      tick();
      rst = 1'b0;
      en  = 1'b0;
      #1;
      chk("rf_rd", 32'(in_rd_en), 0);
      chk("rf_wr", 32'(out_wr_en), 0);
      chk("rf_ab", 32'({dut_a, dut_b}), 0);
      chk("rf_busy", 32'(busy), 0);
      chk("rf_din", 32'(out_din), 0);
      wbase = wcnt0 + wcnt1;
      repeat (2) tick();
      rst = 1'b1;
      repeat (3) tick();
      chk("rf_no_write", 32'(wcnt0 + wcnt1 - wbase), 0);
      n0 = pop0;
      n1 = pop1;

      // overflow pop at full credit
      out_rd = 2'b10;
      #1;
      tick();
      out_rd = 2'b00;
      #1;
      chk("er_set", 32'(err), 32'(ERR_EXP));
      tick();
      chk("er_sticky", 32'(err), 32'(ERR_EXP));
      for (int i = 0; i < 10; i++) begin
         push0(2'(i));
         push1(2'(i + 1));
      end
      base0 = pop0;
      base1 = pop1;
      en = 1'b1;
      #1;
      repeat (24) tick();
      chk("cr_pops0", 32'(pop0 - base0), 8);
      chk("cr_pops1", 32'(pop1 - base1), 8);
      chk("cr_stall", 32'(in_rd_en), 0);
      chk("er_final", 32'(err), 32'(ERR_EXP));
      chk("onehot", 32'(bad), 0);
      en = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/xor_path_sched.md
# xor_path_sched

Two-channel round-robin scheduler that shares the single XOR `dut` between two input FIFO/output FIFO pairs. It pops one 2-bit word per cycle from an eligible input FIFO and drives it onto the `dut` `a`/`b` inputs. It tracks each operation through the `dut` latency and writes the 1-bit result into the output FIFO of the originating channel. Credit counters guarantee an output FIFO is never written when full.

## Interface
- `DUT_LAT`, default 1: cycles from `dut_a`/`dut_b` registered to a valid `dut_out`; legal range 1..8.
- `OUT_DEPTH`, default 8: depth of each output FIFO; initial credit per channel; legal range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: issue enable; low stops new issues and drains in-flight operations.
- `in_empty` in 2: empty flags of input FIFO 0/1 (first-word-fall-through).
- `in_data0` in 2: head word of input FIFO 0, valid while `in_empty[0]`=0.
- `in_data1` in 2: head word of input FIFO 1.
- `in_rd_en` out 2: one-hot pop strobe to input FIFOs.
- `dut_a`, `dut_b` out 1 each: registered operands to `dut`.
- `dut_out` in 1: `dut` result.
- `out_wr_en` out 2: one-hot write strobe to output FIFOs.
- `out_din` out 1: write data, shared by both output FIFOs.
- `out_rd` in 2: downstream pops of output FIFO 0/1; each returns one credit.
- `busy` out 1: high in RUN or DRAIN.
- `err` out 1: sticky credit-overflow flag (see Configuration).

## Operation
- Channel ch is eligible when `in_empty[ch]`=0 and `credit[ch]`>0.
- State machine:
  - IDLE → RUN when `en`=1.
  - RUN → DRAIN when `en`=0 and at least one operation is in flight.
  - RUN → IDLE when `en`=0 and the pipeline is empty.
  - DRAIN → IDLE when the pipeline is empty.
  - DRAIN → RUN when `en`=1.
  - Issues occur only in RUN with `en`=1.
- Arbitration: round-robin with last-grant pointer `lp`.
  - The channel ≠ `lp` has priority.
  - A sole eligible channel is granted regardless of `lp`.
  - `lp` updates only on a grant.
  - Reset `lp`=1, so channel 0 wins the first contention.
- Grant on channel g in cycle c:
  - `in_rd_en[g]`=1 in cycle c (combinational from registered state and inputs).
  - `credit[g]` decrements.
  - `{dut_a,dut_b}` ← `in_data_g` at edge c.
  - `{valid=1, id=g}` enters the tag delay line.
- Tag delay line: `DUT_LAT`+1 stages. When stage-last `valid`=1:
  - `out_wr_en[id]`=1
  - `out_din`=`dut_out`
- `dut_a`/`dut_b` hold their last value when there is no grant.
- Credits, per channel, 0..`OUT_DEPTH`:
  - +1 on `out_rd[ch]`; −1 on grant.
  - Both in the same cycle: unchanged.
  - A grant is never made at credit 0.
  - `out_rd` at credit=`OUT_DEPTH` is ignored, and `err` is set when compiled in.
- At most one grant per cycle; throughput is one op/cycle aggregate.
- Reset mid-operation: all in-flight tags are discarded, credits return to `OUT_DEPTH`, and no `out_wr_en` is produced after reset.

## Timing
- Reset values:
  - `in_rd_en`=0, `dut_a`=`dut_b`=0, `out_wr_en`=0, `out_din`=0
  - `busy`=0, `err`=0
  - state IDLE, `lp`=1, credits=`OUT_DEPTH`, tag line all invalid
- Latency: pop in cycle c → `out_wr_en` in cycle c+1+`DUT_LAT`.
- `busy` is registered and reflects state. It falls the cycle after the last `out_wr_en`.
- `en` falling in cycle c: no `in_rd_en` from cycle c onward.
- Credit returned by `out_rd` in cycle c is usable for a grant in cycle c+1.

## Configuration
- `XOR_PATH_SCHED_ERR_EN` defined:
  - `err` is a sticky register.
  - It sets on `out_rd[ch]` while `credit[ch]`=`OUT_DEPTH`.
  - It clears only on reset.
- Undefined: `err` is tied 0 and no detection logic is built. The credit-overflow pop is still ignored.

## Test plan
- Reset mid-flight: pop at cycle 3, assert `rst`=0 at cycle 4 → outputs at reset values, no `out_wr_en` ever appears, credits=8 after release.
- Single channel: ch0 FIFO holds words 2'b01, 2'b11, 2'b10, ch1 empty, `en`=1, `DUT_LAT`=1 → `in_rd_en`=01 on 3 consecutive cycles; `out_wr_en`=01 two cycles after each pop with `out_din`=1,0,1; `busy` drops after the drain.
- Contention: both FIFOs non-empty for 6 cycles after reset → grants alternate 0,1,0,1,0,1; each `out_wr_en` bit matches its channel's result.
- Backpressure: `OUT_DEPTH`=2, ch0 has 5 words, no `out_rd` → exactly 2 pops, then stall. Pulse `out_rd[0]` once → exactly one more pop, on the following cycle.
- Drain: `en` falls one cycle after a pop with `DUT_LAT`=3 → no further pops; the pending `out_wr_en` still fires; state DRAIN→IDLE; `busy`=0 afterwards.
- Error: with `XOR_PATH_SCHED_ERR_EN`, pulse `out_rd[1]` at full credit → `err`=1 next cycle, stays 1, and credit remains 8. Without the macro → `err` stays 0.
